// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: control-word bit positions,
// opcode and microstep encodings, and the per-opcode last-step lookup.
package cpu_ctrl_pkg;

    // Default number of microsteps per instruction (T0..T4)
    localparam int NUM_STEPS_DEFAULT = 5;

    // Width of the control word driven to the datapath
    localparam int CTRL_W = 16;

    // Bit positions inside the active-high control word
    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    // One-hot masks built from the bit positions above
    localparam logic [CTRL_W-1:0] C_HLT = CTRL_W'(1 << B_HLT);
    localparam logic [CTRL_W-1:0] C_MI  = CTRL_W'(1 << B_MI);
    localparam logic [CTRL_W-1:0] C_RI  = CTRL_W'(1 << B_RI);
    localparam logic [CTRL_W-1:0] C_RO  = CTRL_W'(1 << B_RO);
    localparam logic [CTRL_W-1:0] C_IO  = CTRL_W'(1 << B_IO);
    localparam logic [CTRL_W-1:0] C_II  = CTRL_W'(1 << B_II);
    localparam logic [CTRL_W-1:0] C_AI  = CTRL_W'(1 << B_AI);
    localparam logic [CTRL_W-1:0] C_AO  = CTRL_W'(1 << B_AO);
    localparam logic [CTRL_W-1:0] C_EO  = CTRL_W'(1 << B_EO);
    localparam logic [CTRL_W-1:0] C_SU  = CTRL_W'(1 << B_SU);
    localparam logic [CTRL_W-1:0] C_BI  = CTRL_W'(1 << B_BI);
    localparam logic [CTRL_W-1:0] C_OI  = CTRL_W'(1 << B_OI);
    localparam logic [CTRL_W-1:0] C_CE  = CTRL_W'(1 << B_CE);
    localparam logic [CTRL_W-1:0] C_CO  = CTRL_W'(1 << B_CO);
    localparam logic [CTRL_W-1:0] C_J   = CTRL_W'(1 << B_J);
    localparam logic [CTRL_W-1:0] C_FI  = CTRL_W'(1 << B_FI);

    // Instruction opcodes (upper nibble of the instruction register);
    // 1001..1101 are undefined and behave as NOP
    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // Microstep indices
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    // Last non-empty microstep of each instruction; everything without an
    // execute phase still spends one (empty) cycle in T2
    function automatic logic [2:0] lastStepOf(input logic [3:0] op);
        logic [2:0] last;
        case (op)
            OP_ADD, OP_SUB: last = T4;
            OP_LDA, OP_STA: last = T3;
            default:        last = T2;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: maps (step, opcode, flags) to the control
// word for that microstep and flags whether this is the instruction's last step.
module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0]        step_i,
    input  logic [3:0]        opcode_i,
    input  logic              flag_c_i,
    input  logic              flag_z_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              last_o
);

    // Table lookup: shared fetch in T0/T1, opcode-specific execute in T2..T4;
    // flags are only looked at in T2 of the conditional jumps
    always_comb begin
        ctrl_o = '0;
        case (step_i)
            T0: ctrl_o = C_CO | C_MI;
            T1: ctrl_o = C_RO | C_II | C_CE;
            T2: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_o = C_IO | C_MI;
                    OP_LDI: ctrl_o = C_IO | C_AI;
                    OP_JMP: ctrl_o = C_IO | C_J;
                    OP_JC:  ctrl_o = flag_c_i ? (C_IO | C_J) : '0;
                    OP_JZ:  ctrl_o = flag_z_i ? (C_IO | C_J) : '0;
                    OP_OUT: ctrl_o = C_AO | C_OI;
                    OP_HLT: ctrl_o = C_HLT;
                    default: ctrl_o = '0;
                endcase
            end
            T3: begin
                case (opcode_i)
                    OP_LDA:         ctrl_o = C_RO | C_AI;
                    OP_ADD, OP_SUB: ctrl_o = C_RO | C_BI;
                    OP_STA:         ctrl_o = C_AO | C_RI;
                    default:        ctrl_o = '0;
                endcase
            end
            T4: begin
                case (opcode_i)
                    OP_ADD:  ctrl_o = C_EO | C_AI | C_FI;
                    OP_SUB:  ctrl_o = C_EO | C_AI | C_FI | C_SU;
                    default: ctrl_o = '0;
                endcase
            end
            default: ctrl_o = '0;
        endcase
    end

    // ">=" rather than "==" so that an opcode change mid-instruction can never
    // strand the counter past the new instruction's final step
    always_comb begin
        last_o = (step_i >= lastStepOf(opcode_i));
    end

endmodule

// File: rtl/control_sequencer.sv
// Microstep sequencer for the 8-bit CPU: owns the step counter and the halt
// latch, and gates the microcode ROM output with reset and halt.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    // Hard ceiling on the counter regardless of what the table says
    localparam logic [2:0] MAX_STEP = 3'(NUM_STEPS - 1);

    logic [2:0]        step_q;
    logic [2:0]        step_d;
    logic              halted_q;
    logic              halted_d;
    logic [CTRL_W-1:0] romCtrl;
    logic              romLast;

    microcode_rom u_rom (
        .step_i   (step_q),
        .opcode_i (opcode),
        .flag_c_i (flag_c),
        .flag_z_i (flag_z),
        .ctrl_o   (romCtrl),
        .last_o   (romLast)
    );

    // Next step/halt: HLT in T2 latches halted and parks the counter at T2;
    // otherwise advance, wrapping to T0 after the instruction's last step
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if ((opcode == OP_HLT) && (step_q == T2)) begin
                halted_d = 1'b1;
            end else if (romLast || (step_q >= MAX_STEP)) begin
                step_d = T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // State registers; clr aborts any instruction and clears the halt latch
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Output word: silent during reset, HLT only once halted, else the table
    always_comb begin
        ctrl = '0;
        if (!clr) begin
            ctrl = halted_q ? C_HLT : romCtrl;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 5, meaning the maximum microsteps per instruction (T0..T4).
REQ-002 SHALL have clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have clr  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have opcode  input  4  instruction register upper nibble I[3:0].
REQ-005 SHALL have flag_c  input  1  registered carry flag.
REQ-006 SHALL have flag_z  input  1  registered zero flag.
REQ-007 SHALL have ctrl  output  16  active-high control word; the CPU top inverts bits that drive *_n ports.
REQ-008 SHALL have step  output  3  current microstep index.
REQ-009 SHALL have halted  output  1  high once HLT has executed.

Function
REQ-010 ctrl bit map SHALL be: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
REQ-011 ctrl SHALL be a combinational function of step, opcode, flag_c, flag_z, halted and clr (zero extra latency).
REQ-012 Fetch for every opcode: T0 = CO|MI; T1 = RO|II|CE.
REQ-013 Execute words (T2/T3/T4): LDA 0001 = IO|MI / RO|AI; ADD 0010 = IO|MI / RO|BI / EO|AI|FI; SUB 0011 = as ADD with SU added at T4; STA 0100 = IO|MI / AO|RI.
REQ-014 Execute words (T2 only): LDI 0101 = IO|AI; JMP 0110 = IO|J; JC 0111 = IO|J if flag_c else 0; JZ 1000 = IO|J if flag_z else 0; OUT 1110 = AO|OI; HLT 1111 = HLT.
REQ-015 NOP 0000 and undefined opcodes 1001..1101 SHALL produce ctrl = 0 in T2..T4.
REQ-016 step SHALL advance by 1 each clock and SHALL return to 0 on the clock after the last non-empty step of the current instruction (early termination).
REQ-017 Last step SHALL be: T4 for ADD/SUB; T3 for LDA/STA; T2 for LDI/JMP/JC/JZ/OUT; T2 for NOP/undefined (one empty cycle); step never exceeds NUM_STEPS-1.
REQ-018 Not-taken JC/JZ SHALL still terminate after T2.
REQ-019 Flags SHALL be sampled combinationally only during T2 of JC/JZ; flag changes at other steps have no effect.
REQ-020 On the rising edge ending T2 of HLT, halted SHALL set; while halted, step SHALL freeze at 2 and ctrl SHALL equal HLT only.
REQ-021 halted SHALL clear only via clr.

Reset
REQ-022 While clr is high: step = 0, halted = 0, ctrl = 0 regardless of other inputs.
REQ-023 clr asserted mid-instruction SHALL abort it immediately; after clr falls, the first rising edge finds step = 0 with ctrl = CO|MI.

Structure
REQ-024 A shared package cpu_ctrl_pkg SHALL hold ctrl bit positions, opcode constants and NUM_STEPS default.
REQ-025 A combinational sub-module microcode_rom (inputs step, opcode, flag_c, flag_z; outputs ctrl word and last-step indicator) SHALL hold the table; step counter and halt latch stay in control_sequencer.

Verification
REQ-026 Reset: clr high with opcode=0010, step held -> step=0, ctrl=0x0000, halted=0; clr low -> ctrl=0x4004.
REQ-027 ADD: opcode=0010 through T0..T4 -> ctrl 0x4004, 0x1408, 0x4800, 0x1020, 0x0281; step then 0.
REQ-028 Early termination: LDI (0101) -> T2 ctrl=0x0A00, next cycle step=0; LDA -> step sequence 0,1,2,3,0.
REQ-029 Conditional jump: JZ with flag_z=1 -> T2 ctrl=0x0802; flag_z=0 -> T2 ctrl=0x0000; both return to step 0 next cycle.
REQ-030 Halt: opcode=1111 -> T2 ctrl=0x8000, halted=1 next edge, step stays 2 for 10 clocks; clr pulse -> halted=0, step=0.
REQ-031 Mid-op reset: assert clr asynchronously during T3 of SUB -> step=0 and ctrl=0 before next clock edge.
